// File: rtl/nrs_top_new_tx_pkg.sv
// Shared definitions for the NB-IoT transmit-side NRS generator.
// Holds the Gold-sequence warm-up length, the two fixed-point pilot words,
// slot sequencing constants, the FSM state type and the bit-to-word helper.
package nrs_top_new_tx_pkg;

    localparam int          NC          = 1600;
    localparam logic [15:0] NRS_POS     = 16'h05A8;   // +1448 = +1/sqrt(2), Q4.11
    localparam logic [15:0] NRS_NEG     = 16'hFA58;   // -1448
    localparam int          NUM_ENTRIES = 16;
    localparam logic [4:0]  SKIP_NS     = 5'd10;      // slot pair of subframe 5 (NPSS)
    localparam logic [4:0]  SKIP_TO_NS  = 5'd12;
    localparam logic [4:0]  LAST_NS     = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CINIT = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GEN   = 2'd3
    } nrs_state_t;

    // Map one Gold-sequence bit onto its +-1/sqrt(2) pilot word.
    function automatic logic [15:0] nrs_word(input logic c);
        logic [15:0] w;
        if (c) begin
            w = NRS_NEG;
        end else begin
            w = NRS_POS;
        end
        return w;
    endfunction

endpackage

// File: rtl/nrs_top_new_tx_gold_seq.sv
// Gold-sequence engine for one OFDM symbol.
//   load    : restart both LFSRs (x1 = 1, x2 = cinit)
//   step    : advance both LFSRs by one position
//   c_bit   : x1(n) ^ x2(n) for the current position n
//   c_valid : high while n is in 1600..1603, i.e. c_bit is c(0)..c(3)
module nrs_gold_seq
    import nrs_top_new_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [30:0] cinit,
    output logic        c_bit,
    output logic        c_valid
);

    localparam logic [10:0] NC_BEGIN = 11'(NC);
    localparam logic [10:0] NC_END   = 11'(NC + 4);

    logic [30:0] x1_r;
    logic [30:0] x2_r;
    logic [10:0] cnt_r;
    logic        valid_r;
    logic [10:0] cnt_next_s;

    assign cnt_next_s = cnt_r + 11'd1;

    // LFSR state, position counter and output-valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x1_r    <= 31'd0;
            x2_r    <= 31'd0;
            cnt_r   <= 11'd0;
            valid_r <= 1'b0;
        end else if (load) begin
            x1_r    <= 31'd1;
            x2_r    <= cinit;
            cnt_r   <= 11'd0;
            valid_r <= 1'b0;
        end else if (step) begin
            // bit 0 holds x(n); the new bit x(n+31) enters at the top
            x1_r    <= {x1_r[3] ^ x1_r[0], x1_r[30:1]};
            x2_r    <= {x2_r[3] ^ x2_r[2] ^ x2_r[1] ^ x2_r[0], x2_r[30:1]};
            cnt_r   <= cnt_next_s;
            valid_r <= (cnt_next_s >= NC_BEGIN) && (cnt_next_s < NC_END);
        end else begin
            valid_r <= valid_r;
        end
    end

    assign c_bit   = x1_r[0] ^ x2_r[0];
    assign c_valid = valid_r;

endmodule

// File: rtl/nrs_top_new_tx.sv
// Transmit-side NRS value generator (NB-IoT).
// On new_frame / new_subframe it produces the 16 pilot words of one NRS
// subframe (symbols l=5,6 of slots ns and ns+1) into a register bank that the
// resource-element mapper reads through four independent registered ports.
//   clk, rst (async active-low)
//   new_frame      : latch N_cell_ID, ns=0, generate
//   new_subframe   : ns += 2 (10 -> 12, stop at 18), generate when idle
//   rd_addr_mapper_{1r,1i,2r,2i} -> nrs_mapper_{1r,1i,2r,2i} one edge later
module nrs_top_new_tx
    import nrs_top_new_tx_pkg::*;
#(
    parameter int WIDTH_REG = 16,
    parameter int WIDTH_B   = 9,
    parameter int LINES     = $clog2(WIDTH_REG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 new_frame,
    input  logic                 new_subframe,
    input  logic [WIDTH_B-1:0]   N_cell_ID,
    input  logic [LINES-1:0]     rd_addr_mapper_1r,
    input  logic [LINES-1:0]     rd_addr_mapper_1i,
    input  logic [LINES-1:0]     rd_addr_mapper_2r,
    input  logic [LINES-1:0]     rd_addr_mapper_2i,
    output logic [WIDTH_REG-1:0] nrs_mapper_1r,
    output logic [WIDTH_REG-1:0] nrs_mapper_1i,
    output logic [WIDTH_REG-1:0] nrs_mapper_2r,
    output logic [WIDTH_REG-1:0] nrs_mapper_2i
);

    localparam logic [10:0] SHIFT_LAST = 11'(NC - 1);

    nrs_state_t           state_r;
    logic [10:0]          phase_r;
    logic [1:0]           sym_r;
    logic [4:0]           ns_r;
    logic [WIDTH_B-1:0]   id_r;
    logic [7:0]           a_r;
    logic [9:0]           b_r;
    logic [WIDTH_REG-1:0] bank_r [NUM_ENTRIES];

    logic [4:0]  slot_s;
    logic [7:0]  a_s;
    logic [17:0] ab_s;
    logic [30:0] cinit_s;
    logic [4:0]  ns_inc_s;
    logic [4:0]  ns_next_s;
    logic        load_s;
    logic        step_s;
    logic        c_bit_s;
    logic        c_valid_s;

    // Symbols 2,3 belong to the odd slot ns+1; symbol bit 0 selects l=5/6.
    assign slot_s = ns_r + {4'd0, sym_r[1]};
    // 7*(slot+1) + l + 1 with l = 5 + sym[0]
    assign a_s    = ({3'd0, slot_s} * 8'd7) + 8'd13 + {7'd0, sym_r[0]};
    assign ab_s   = {10'd0, a_r} * {8'd0, b_r};
    assign cinit_s = {3'd0, ab_s, 10'd0} + {21'd0, b_r};

    assign ns_inc_s  = ns_r + 5'd2;
    assign ns_next_s = (ns_inc_s == SKIP_NS) ? SKIP_TO_NS : ns_inc_s;

    assign load_s = (state_r == ST_CINIT) && (phase_r == 11'd1);
    assign step_s = (state_r == ST_SHIFT) || (state_r == ST_GEN);

    nrs_gold_seq u_gold (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .step    (step_s),
        .cinit   (cinit_s),
        .c_bit   (c_bit_s),
        .c_valid (c_valid_s)
    );

    // Sequencing FSM: trigger handling, slot counter and symbol/phase counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            phase_r <= 11'd0;
            sym_r   <= 2'd0;
            ns_r    <= 5'd0;
            id_r    <= '0;
        end else if (new_frame) begin
            // also aborts a generation in flight
            state_r <= ST_CINIT;
            phase_r <= 11'd0;
            sym_r   <= 2'd0;
            ns_r    <= 5'd0;
            id_r    <= N_cell_ID;
        end else if (new_subframe && (state_r == ST_IDLE) && (ns_r != LAST_NS)) begin
            state_r <= ST_CINIT;
            phase_r <= 11'd0;
            sym_r   <= 2'd0;
            ns_r    <= ns_next_s;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    phase_r <= 11'd0;
                end
                ST_CINIT: begin
                    if (phase_r == 11'd1) begin
                        state_r <= ST_SHIFT;
                        phase_r <= 11'd0;
                    end else begin
                        phase_r <= phase_r + 11'd1;
                    end
                end
                ST_SHIFT: begin
                    if (phase_r == SHIFT_LAST) begin
                        state_r <= ST_GEN;
                        phase_r <= 11'd0;
                    end else begin
                        phase_r <= phase_r + 11'd1;
                    end
                end
                ST_GEN: begin
                    if (phase_r == 11'd3) begin
                        phase_r <= 11'd0;
                        if (sym_r == 2'd3) begin
                            state_r <= ST_IDLE;
                            sym_r   <= 2'd0;
                        end else begin
                            state_r <= ST_CINIT;
                            sym_r   <= sym_r + 2'd1;
                        end
                    end else begin
                        phase_r <= phase_r + 11'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    phase_r <= 11'd0;
                end
            endcase
        end
    end

    // First multiplier stage: register the two cinit factors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r <= 8'd0;
            b_r <= 10'd0;
        end else if ((state_r == ST_CINIT) && (phase_r == 11'd0)) begin
            a_r <= a_s;
            b_r <= {id_r, 1'b1};
        end else begin
            a_r <= a_r;
            b_r <= b_r;
        end
    end

    // Register bank: one entry written per GEN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                bank_r[i] <= '0;
            end
        end else if ((state_r == ST_GEN) && c_valid_s) begin
            bank_r[{sym_r, phase_r[1:0]}] <= nrs_word(c_bit_s);
        end else begin
            bank_r <= bank_r;
        end
    end

    // Four independent registered read ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nrs_mapper_1r <= '0;
            nrs_mapper_1i <= '0;
            nrs_mapper_2r <= '0;
            nrs_mapper_2i <= '0;
        end else begin
            nrs_mapper_1r <= bank_r[rd_addr_mapper_1r];
            nrs_mapper_1i <= bank_r[rd_addr_mapper_1i];
            nrs_mapper_2r <= bank_r[rd_addr_mapper_2r];
            nrs_mapper_2i <= bank_r[rd_addr_mapper_2i];
        end
    end

endmodule

// File: tb/tb_nrs_top_new_tx.sv
// Self-checking bench for nrs_top_new_tx: randomized cell IDs and read
// addresses, checked against a Gold-sequence model built directly from the
// recurrence definitions with bit arrays.
module tb_nrs_top_new_tx;

    logic        clk;
    logic        rst;
    logic        new_frame;
    logic        new_subframe;
    logic [8:0]  N_cell_ID;
    logic [3:0]  rd_addr_mapper_1r;
    logic [3:0]  rd_addr_mapper_1i;
    logic [3:0]  rd_addr_mapper_2r;
    logic [3:0]  rd_addr_mapper_2i;
    logic [15:0] nrs_mapper_1r;
    logic [15:0] nrs_mapper_1i;
    logic [15:0] nrs_mapper_2r;
    logic [15:0] nrs_mapper_2i;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_bank [16];

    nrs_top_new_tx dut (
        .clk               (clk),
        .rst               (rst),
        .new_frame         (new_frame),
        .new_subframe      (new_subframe),
        .N_cell_ID         (N_cell_ID),
        .rd_addr_mapper_1r (rd_addr_mapper_1r),
        .rd_addr_mapper_1i (rd_addr_mapper_1i),
        .rd_addr_mapper_2r (rd_addr_mapper_2r),
        .rd_addr_mapper_2i (rd_addr_mapper_2i),
        .nrs_mapper_1r     (nrs_mapper_1r),
        .nrs_mapper_1i     (nrs_mapper_1i),
        .nrs_mapper_2r     (nrs_mapper_2r),
        .nrs_mapper_2i     (nrs_mapper_2i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    // Reference: cinit formula, then x1/x2 recurrences straight from their definitions.
    task automatic build_model(input int id, input int ns);
        bit x1 [0:1634];
        bit x2 [0:1634];
        int slot;
        int l;
        int cinit;
        for (int s = 0; s < 4; s++) begin
            slot  = ns + s / 2;
            l     = 5 + s % 2;
            cinit = 1024 * (7 * (slot + 1) + l + 1) * (2 * id + 1) + 2 * id + 1;
            for (int i = 0; i < 31; i++) begin
                x1[i] = (i == 0);
                x2[i] = bit'((cinit >> i) & 1);
            end
            for (int n = 0; n < 1604; n++) begin
                x1[n + 31] = x1[n + 3] ^ x1[n];
                x2[n + 31] = x2[n + 3] ^ x2[n + 2] ^ x2[n + 1] ^ x2[n];
            end
            for (int k = 0; k < 4; k++) begin
                exp_bank[4 * s + k] = (x1[1600 + k] ^ x2[1600 + k]) ? 16'hFA58 : 16'h05A8;
            end
        end
    endtask

    // Read all 16 entries through the four ports with a random rotation,
    // then hit one random entry on all ports at once.
    task automatic check_bank(input string tag);
        int rot;
        int a [4];
        int same;
        for (int base = 0; base < 16; base += 4) begin
            rot = $urandom_range(0, 3);
            for (int p = 0; p < 4; p++) begin
                a[p] = base + (p + rot) % 4;
            end
            rd_addr_mapper_1r = 4'(a[0]);
            rd_addr_mapper_1i = 4'(a[1]);
            rd_addr_mapper_2r = 4'(a[2]);
            rd_addr_mapper_2i = 4'(a[3]);
            tick();
            check_eq($sformatf("%s 1r[%0d]", tag, a[0]), nrs_mapper_1r, exp_bank[a[0]]);
            check_eq($sformatf("%s 1i[%0d]", tag, a[1]), nrs_mapper_1i, exp_bank[a[1]]);
            check_eq($sformatf("%s 2r[%0d]", tag, a[2]), nrs_mapper_2r, exp_bank[a[2]]);
            check_eq($sformatf("%s 2i[%0d]", tag, a[3]), nrs_mapper_2i, exp_bank[a[3]]);
        end
        same = $urandom_range(0, 15);
        rd_addr_mapper_1r = 4'(same);
        rd_addr_mapper_1i = 4'(same);
        rd_addr_mapper_2r = 4'(same);
        rd_addr_mapper_2i = 4'(same);
        tick();
        check_eq($sformatf("%s same1r[%0d]", tag, same), nrs_mapper_1r, exp_bank[same]);
        check_eq($sformatf("%s same1i[%0d]", tag, same), nrs_mapper_1i, exp_bank[same]);
        check_eq($sformatf("%s same2r[%0d]", tag, same), nrs_mapper_2r, exp_bank[same]);
        check_eq($sformatf("%s same2i[%0d]", tag, same), nrs_mapper_2i, exp_bank[same]);
    endtask

    task automatic pulse_frame(input int id);
        N_cell_ID = 9'(id);
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    task automatic pulse_subframe();
        new_subframe = 1'b1;
        tick();
        new_subframe = 1'b0;
    endtask

    int ns_seq [9] = '{0, 2, 4, 6, 8, 12, 14, 16, 18};
    int rid;

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst               = 1'b0;
        new_frame         = 1'b0;
        new_subframe      = 1'b0;
        N_cell_ID         = 9'd0;
        rd_addr_mapper_1r = 4'd0;
        rd_addr_mapper_1i = 4'd0;
        rd_addr_mapper_2r = 4'd0;
        rd_addr_mapper_2i = 4'd0;
        wait_cycles(4);
        rst = 1'b1;
        tick();

        // reset state: every entry reads zero
        for (int i = 0; i < 16; i++) begin
            exp_bank[i] = 16'h0000;
        end
        check_bank("reset");

        // cell 0, subframe 0
        pulse_frame(0);
        wait_cycles(6424);
        build_model(0, 0);
        check_bank("id0_ns0");

        // subframe sweep for cell 503, including the NPSS skip
        pulse_frame(503);
        wait_cycles(6424);
        build_model(503, 0);
        check_bank("id503_ns0");
        for (int k = 1; k < 9; k++) begin
            pulse_subframe();
            wait_cycles(6424);
            build_model(503, ns_seq[k]);
            check_bank($sformatf("id503_ns%0d", ns_seq[k]));
        end
        // past slot 18 a further new_subframe must leave the bank alone
        pulse_subframe();
        wait_cycles(1700);
        check_bank("id503_after18");

        // abort mid-SHIFT with a simultaneous new_subframe; new_frame wins
        pulse_frame(7);
        wait_cycles(800);
        N_cell_ID    = 9'd1;
        new_frame    = 1'b1;
        new_subframe = 1'b1;
        tick();
        new_frame    = 1'b0;
        new_subframe = 1'b0;
        wait_cycles(6424);
        build_model(1, 0);
        check_bank("abort_id1");

        // random cell; ID changes and a busy new_subframe must be ignored
        rid = $urandom_range(0, 503);
        pulse_frame(rid);
        wait_cycles(100);
        N_cell_ID = 9'($urandom_range(0, 503));
        pulse_subframe();
        wait_cycles(6323);
        build_model(rid, 0);
        check_bank($sformatf("rnd_id%0d_ns0", rid));
        pulse_subframe();
        wait_cycles(6424);
        build_model(rid, 2);
        check_bank($sformatf("rnd_id%0d_ns2", rid));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
